// File: rtl/mul_hilo_ctrl.sv
// HI/LO register file and start/stall sequencer for the iterative multiplier.
// Holds operands stable while the multiplier runs and captures its product.
module mul_hilo_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_mult_req,
    input  logic        ex_mult_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        ex_cancel,
    output logic        stall,
    output logic        mult_begin,
    output logic        mult_signed,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] product,
    input  logic        mult_end,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;
    logic        begin_q, begin_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Hold EX while its multiply is outstanding; release in the completion cycle.
    assign stall = ex_mult_req & ~ex_cancel
                 & ~((state_q == BUSY) & mult_end);

    // Next-state, operand latch and HI/LO write selection.
    always_comb begin
        state_d  = state_q;
        begin_d  = begin_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // A multiply in the EX slot shadows any mt* that arrives with it.
        if (~ex_cancel & ~ex_mult_req) begin
            if (ex_mthi) hi_d = ex_wdata;
            if (ex_mtlo) lo_d = ex_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (ex_mult_req & ~ex_cancel) begin
                    op1_d    = ex_op1;
                    op2_d    = ex_op2;
                    signed_d = ex_mult_signed;
                    begin_d  = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Flush wins: the product of a cancelled instruction is dropped.
                if (ex_cancel) begin
                    begin_d = 1'b0;
                    state_d = IDLE;
                end else if (mult_end) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    begin_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                begin_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            begin_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            begin_q  <= begin_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mult_begin  = begin_q;
    assign mult_signed = signed_q;
    assign mult_op1    = op1_q;
    assign mult_op2    = op2_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural iterative multiplier.
// Expected HI/LO values are hand-computed constants.
module tb_mul_hilo_ctrl;

    logic        clk;
    logic        resetn;
    logic        ex_mult_req;
    logic        ex_mult_signed;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        ex_mthi;
    logic        ex_mtlo;
    logic [31:0] ex_wdata;
    logic        ex_cancel;
    logic        stall;
    logic        mult_begin;
    logic        mult_signed;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tot;
    int n_bad;

    mul_hilo_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .ex_mult_req    (ex_mult_req),
        .ex_mult_signed (ex_mult_signed),
        .ex_op1         (ex_op1),
        .ex_op2         (ex_op2),
        .ex_mthi        (ex_mthi),
        .ex_mtlo        (ex_mtlo),
        .ex_wdata       (ex_wdata),
        .ex_cancel      (ex_cancel),
        .stall          (stall),
        .mult_begin     (mult_begin),
        .mult_signed    (mult_signed),
        .mult_op1       (mult_op1),
        .mult_op2       (mult_op2),
        .product        (product),
        .mult_end       (mult_end),
        .hi             (hi),
        .lo             (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: completion in cycle 2 + bitlen(|op2|) after begin rises.
    logic [63:0] m_prod;
    int          m_cnt;
    logic        m_busy;
    logic        m_done;

    function automatic int blen(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [63:0] full_prod(input logic sg,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sg ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic int lat_of(input logic sg, input logic [31:0] b);
        logic [31:0] m;
        m = (sg && b[31]) ? -b : b;
        return 2 + blen(m);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            m_prod   <= 64'd0;
            mult_end <= 1'b0;
        end else begin
            mult_end <= 1'b0;
            if (!mult_begin) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end else if (m_done) begin
                m_done <= 1'b1;
            end else if (!m_busy) begin
                m_busy <= 1'b1;
                m_prod <= full_prod(mult_signed, mult_op1, mult_op2);
                if (lat_of(mult_signed, mult_op2) == 2) begin
                    mult_end <= 1'b1;
                    m_done   <= 1'b1;
                end else begin
                    m_cnt <= lat_of(mult_signed, mult_op2) - 3;
                end
            end else if (m_cnt == 0) begin
                mult_end <= 1'b1;
                m_done   <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign product = mult_end ? m_prod : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sg, input logic [31:0] a,
                         input logic [31:0] b);
        ex_mult_req    = 1'b1;
        ex_mult_signed = sg;
        ex_op1         = a;
        ex_op2         = b;
    endtask

    // Called just after an edge with a request newly presented in IDLE.
    task automatic finish_mult(input string tag, output int lat);
        @(negedge clk);
        chk({tag, "_stall_req"}, 64'(stall), 64'(1));
        chk({tag, "_beg_gap"}, 64'(mult_begin), 64'(0));
        step();
        chk({tag, "_beg_up"}, 64'(mult_begin), 64'(1));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !mult_end)
                chk({tag, "_stall_busy"}, 64'(stall), 64'(1));
        end while (!mult_end && lat < 60);
        if (!mult_end)
            chk({tag, "_timeout"}, 64'(0), 64'(1));
        chk({tag, "_stall_end"}, 64'(stall), 64'(0));
        step();
    endtask

    int lat;

    initial begin
        n_tot          = 0;
        n_bad          = 0;
        resetn         = 1'b1;
        ex_mult_req    = 1'b0;
        ex_mult_signed = 1'b0;
        ex_op1         = 32'd0;
        ex_op2         = 32'd0;
        ex_mthi        = 1'b0;
        ex_mtlo        = 1'b0;
        ex_wdata       = 32'd0;
        ex_cancel      = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_beg", 64'(mult_begin), 64'(0));
        chk("rst_sg", 64'(mult_signed), 64'(0));
        chk("rst_op1", 64'(mult_op1), 64'(0));
        chk("rst_op2", 64'(mult_op2), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        ex_mult_req = 1'b1;
        #1;
        chk("rst_stall_req", 64'(stall), 64'(1));
        ex_mult_req = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_mult("mu_ff", lat);
        ex_mult_req = 1'b0;
        chk("mu_ff_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("mu_ff_lo", 64'(lo), 64'h0000_0000_0000_0001);
        chk("mu_ff_beg_dn", 64'(mult_begin), 64'(0));

        issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        finish_mult("m_m3x7", lat);
        ex_mult_req = 1'b0;
        chk("m_m3x7_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("m_m3x7_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);

        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        finish_mult("m_min", lat);
        ex_mult_req = 1'b0;
        chk("m_min_hi", 64'(hi), 64'h0000_0000_4000_0000);
        chk("m_min_lo", 64'(lo), 64'h0);

        issue(1'b0, 32'h1234_5678, 32'h0);
        finish_mult("mu_z", lat);
        ex_mult_req = 1'b0;
        chk("mu_z_lat", 64'(lat), 64'(2));
        chk("mu_z_hi", 64'(hi), 64'h0);
        chk("mu_z_lo", 64'(lo), 64'h0);
        chk("mu_z_op1", 64'(mult_op1), 64'h1234_5678);

        ex_mthi  = 1'b1;
        ex_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_stall", 64'(stall), 64'(0));
        step();
        ex_mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        ex_mtlo  = 1'b1;
        ex_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("mtlo_stall", 64'(stall), 64'(0));
        step();
        ex_mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
        chk("mtlo_hi", 64'(hi), 64'hDEAD_BEEF);

        issue(1'b0, 32'd2, 32'd3);
        finish_mult("b2b_a", lat);
        issue(1'b0, 32'd5, 32'd5);
        chk("b2b_a_hi", 64'(hi), 64'h0);
        chk("b2b_a_lo", 64'(lo), 64'd6);
        chk("b2b_a_beg", 64'(mult_begin), 64'(0));
        finish_mult("b2b_b", lat);
        ex_mult_req = 1'b0;
        chk("b2b_b_lo", 64'(lo), 64'd25);

        ex_mthi  = 1'b1;
        ex_wdata = 32'hAAAA_AAAA;
        issue(1'b0, 32'd3, 32'd3);
        finish_mult("prio", lat);
        ex_mult_req = 1'b0;
        ex_mthi     = 1'b0;
        chk("prio_hi", 64'(hi), 64'h0);
        chk("prio_lo", 64'(lo), 64'd9);

        ex_mthi  = 1'b1;
        ex_wdata = 32'h1111_1111;
        step();
        ex_mthi  = 1'b0;
        ex_mtlo  = 1'b1;
        ex_wdata = 32'h2222_2222;
        step();
        ex_mtlo = 1'b0;
        issue(1'b1, 32'd100, 32'd100);
        step();
        chk("cx_beg", 64'(mult_begin), 64'(1));
        step();
        step();
        ex_cancel = 1'b1;
        @(negedge clk);
        chk("cx_stall", 64'(stall), 64'(0));
        step();
        ex_cancel   = 1'b0;
        ex_mult_req = 1'b0;
        chk("cx_beg_dn", 64'(mult_begin), 64'(0));
        chk("cx_hi", 64'(hi), 64'h1111_1111);
        chk("cx_lo", 64'(lo), 64'h2222_2222);
        step();

        issue(1'b1, 32'd100, 32'd100);
        step();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mult_end && lat < 60);
        if (!mult_end)
            chk("ce_timeout", 64'(0), 64'(1));
        ex_cancel = 1'b1;
        #1;
        chk("ce_stall", 64'(stall), 64'(0));
        step();
        ex_cancel   = 1'b0;
        ex_mult_req = 1'b0;
        chk("ce_beg_dn", 64'(mult_begin), 64'(0));
        chk("ce_hi", 64'(hi), 64'h1111_1111);
        chk("ce_lo", 64'(lo), 64'h2222_2222);
        step();

        issue(1'b0, 32'd7, 32'd7);
        ex_cancel = 1'b1;
        ex_mthi   = 1'b1;
        ex_wdata  = 32'h5555_5555;
        @(negedge clk);
        chk("cs_stall", 64'(stall), 64'(0));
        step();
        chk("cs_beg", 64'(mult_begin), 64'(0));
        chk("cs_hi", 64'(hi), 64'h1111_1111);
        ex_mult_req = 1'b0;
        ex_cancel   = 1'b0;
        ex_mthi     = 1'b0;
        step();

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        step();
        step();
        #2 resetn = 1'b0;
        #1;
        chk("rm_hi", 64'(hi), 64'h0);
        chk("rm_lo", 64'(lo), 64'h0);
        chk("rm_beg", 64'(mult_begin), 64'(0));
        chk("rm_op1", 64'(mult_op1), 64'h0);
        chk("rm_stall", 64'(stall), 64'(1));
        ex_mult_req = 1'b0;
        step();
        resetn = 1'b1;
        step();
        issue(1'b0, 32'd4, 32'd4);
        finish_mult("rm_4x4", lat);
        ex_mult_req = 1'b0;
        chk("rm_4x4_hi", 64'(hi), 64'h0);
        chk("rm_4x4_lo", 64'(lo), 64'd16);

        step();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
